// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default bit timing.
package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int CLOCKPERBIT = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_receive_if.sv
// Receiver-side bus: serial input plus the byte/status outputs to the control logic.
// parityerr only exists when UART_RX_PARITY_EN is defined.
interface uart_receive_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rxdata;
    logic                 rxvalid;
    logic                 rxbusy;
    logic                 frameerr;
`ifdef UART_RX_PARITY_EN
    logic                 parityerr;

    modport master (input rx, output rxdata, output rxvalid, output rxbusy,
                    output frameerr, output parityerr);
    modport slave  (output rx, input rxdata, input rxvalid, input rxbusy,
                    input frameerr, input parityerr);
`else
    modport master (input rx, output rxdata, output rxvalid, output rxbusy,
                    output frameerr);
    modport slave  (output rx, input rxdata, input rxvalid, input rxbusy,
                    input frameerr);
`endif

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input; both flops reset to 1.
module uart_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver sampling each bit at its midpoint; define UART_RX_PARITY_EN for an
// extra even-parity bit (8E1) with a parityerr pulse in place of rxvalid on mismatch.
module uart_receive
    import uart_pkg::*;
#(
    parameter int clockperbit = CLOCKPERBIT
) (
    input  logic           clock,
    input  logic           reset,
    uart_receive_if.master bus
);

    localparam int HALFBIT = clockperbit / 2;
    localparam int CNTW    = $clog2(clockperbit);

    localparam logic [CNTW-1:0] HALF_LOAD = CNTW'(HALFBIT - 1);
    localparam logic [CNTW-1:0] BIT_LOAD  = CNTW'(clockperbit - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNTW-1:0]      count;
    logic [2:0]           bitidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    uart_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

    assign bus.rxbusy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            bitidx       <= '0;
            shreg        <= '0;
            bus.rxdata   <= '0;
            bus.rxvalid  <= 1'b0;
            bus.frameerr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            bus.parityerr <= 1'b0;
`endif
        end else begin
            bus.rxvalid  <= 1'b0;
            bus.frameerr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parityerr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        count <= HALF_LOAD;
                    end
                end
                // A start bit that is high again at its midpoint is treated as a glitch.
                START: begin
                    if (count == '0) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state  <= DATA;
                            count  <= BIT_LOAD;
                            bitidx <= '0;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DATA: begin
                    if (count == '0) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        count <= BIT_LOAD;
                        if (bitidx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitidx <= bitidx + 3'd1;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (count == '0) begin
                        par_bit <= rx_s;
                        count   <= BIT_LOAD;
                        state   <= STOP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (count == '0) begin
                        if (rx_s) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{shreg, par_bit}) begin
                                bus.parityerr <= 1'b1;
                            end else begin
                                bus.rxdata  <= shreg;
                                bus.rxvalid <= 1'b1;
                            end
`else
                            bus.rxdata  <= shreg;
                            bus.rxvalid <= 1'b1;
`endif
                        end else begin
                            bus.frameerr <= 1'b1;
                            state        <= BREAK;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                // Hold here while the line stays low so a stuck line cannot spawn new frames.
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// Randomised self-checking bench for uart_receive; expected pulses are predicted from frame
// start times with the receiver's timing rules. Honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_receive;
    import uart_pkg::*;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   fails  = 0;

    typedef struct {
        int         when;
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        expq[$];
    logic [7:0] last_good = 8'h00;

    uart_receive_if bus ();

    uart_receive #(.clockperbit(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Drive one frame from a negedge; the pulse lands 2 sync cycles + half a bit + NBITS bits later.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_ok, input bit par_ok);
        ev_t             e;
        logic [NBITS:0]  frame;
`ifdef UART_RX_PARITY_EN
        frame = {stop_ok, (par_ok ? ^data : ~^data), data, 1'b0};
`else
        frame = {stop_ok, data, 1'b0};
`endif
        e.when = cyc + 1 + 2 + HALF + NBITS * CPB;
        if (!stop_ok) begin
            e.kind = 1;
            e.data = last_good;
`ifdef UART_RX_PARITY_EN
        end else if (!par_ok) begin
            e.kind = 2;
            e.data = last_good;
`endif
        end else begin
            e.kind    = 0;
            e.data    = data;
            last_good = data;
        end
        expq.push_back(e);
        for (int i = 0; i <= NBITS; i++) begin
            bus.rx = frame[i];
            repeat (CPB) @(negedge clock);
        end
    endtask

    task automatic idleLine(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic glitch(input int len);
        int c;
        c      = cyc;
        bus.rx = 1'b0;
        while (cyc < c + 12) begin
            @(negedge clock);
            if (cyc == c + len) bus.rx = 1'b1;
            if (cyc == c + 3) checkOutput("glitch_busy_rise", bus.rxbusy, 1);
            if (cyc == c + 2 + HALF) checkOutput("glitch_busy_hold", bus.rxbusy, 1);
            if (cyc == c + 3 + HALF) checkOutput("glitch_busy_fall", bus.rxbusy, 0);
        end
    endtask

    task automatic badStop(input logic [7:0] data, input int hold);
        applyStimulus(data, 1'b0, 1'b1);
        repeat (hold) @(negedge clock);
        idleLine(3);
    endtask

    task automatic resetMidFrame();
        logic [7:0] d;
        d      = 8'($urandom);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            bus.rx = d[i];
            repeat (CPB) @(negedge clock);
        end
        reset  = 1'b0;
        bus.rx = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checkOutput("rst_rxdata", bus.rxdata, 0);
            checkOutput("rst_rxvalid", bus.rxvalid, 0);
            checkOutput("rst_rxbusy", bus.rxbusy, 0);
            checkOutput("rst_frameerr", bus.frameerr, 0);
        end
        reset     = 1'b1;
        last_good = 8'h00;
        repeat (5) @(negedge clock);
    endtask

    always @(negedge clock) begin : monitor
        logic [2:0] obs;
        if (reset) begin
            obs = {1'b0, bus.frameerr, bus.rxvalid};
`ifdef UART_RX_PARITY_EN
            obs[2] = bus.parityerr;
`endif
            while (expq.size() > 0 && expq[0].when < cyc) begin
                checkOutput("missing_pulse", cyc, expq[0].when);
                void'(expq.pop_front());
            end
            if (obs != 3'b000) begin
                if (expq.size() == 0) begin
                    checkOutput("spurious_pulse", obs, 0);
                end else begin
                    checkOutput("pulse_cycle", cyc, expq[0].when);
                    checkOutput("pulse_kind", obs, 32'(1) << expq[0].kind);
                    checkOutput("pulse_rxdata", bus.rxdata, expq[0].data);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        int sel;
        bus.rx = 1'b1;
        reset  = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_rxdata", bus.rxdata, 0);
        checkOutput("reset_rxvalid", bus.rxvalid, 0);
        checkOutput("reset_rxbusy", bus.rxbusy, 0);
        checkOutput("reset_frameerr", bus.frameerr, 0);
        reset = 1'b1;
        idleLine(5);

        applyStimulus(8'hA5, 1'b1, 1'b1);
        idleLine(10);
        applyStimulus(8'h00, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        idleLine(10);
        glitch(3);
        idleLine(5);
        badStop(8'h3C, 50);
        applyStimulus(8'h12, 1'b1, 1'b1);
        idleLine(5);
        resetMidFrame();
        applyStimulus(8'h5A, 1'b1, 1'b1);
        idleLine(5);
`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b1);
        applyStimulus(8'h07, 1'b1, 1'b0);
        idleLine(5);
`endif

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                glitch($urandom_range(1, HALF));
                idleLine($urandom_range(1, 5));
            end else if (sel == 1) begin
                badStop(8'($urandom), $urandom_range(0, 50));
            end else if (sel == 2) begin
                applyStimulus(8'($urandom), 1'b1, 1'b0);
                idleLine($urandom_range(0, 15));
            end else begin
                applyStimulus(8'($urandom), 1'b1, 1'b1);
                idleLine($urandom_range(0, 15));
            end
        end

        idleLine(3 * NBITS * CPB);
        while (expq.size() > 0) begin
            checkOutput("missing_pulse_end", cyc, expq[0].when);
            void'(expq.pop_front());
        end
        checkOutput("final_rxdata", bus.rxdata, last_good);
        checkOutput("final_rxbusy", bus.rxbusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
